// File: rtl/triangle_fetch_scheduler.sv
// triangle_fetch_scheduler: issues position/normal/material reads per
// triangle FIFO entry and gates new entries on FIFO credit.
//
// Ports:
//   clk_in, rst_in            clock, async active-low reset
//   start_in, entry_count_in  job launch and entry count
//   pos/nrm/mat_base_in       attribute word base addresses
//   abort_in                  stop issuing, back to idle
//   mem_req_*                 shared read request port (valid/ready)
//   fifo_pop_*_in             snooped FIFO pop handshake (credit return)
//   occupancy_out             entries reserved and not yet popped
//   busy_out, done_out        job status
//   underflow_out             sticky pop-while-empty flag
module triangle_fetch_scheduler #(
  parameter int DEPTH = 8192,
  parameter int CNT_W = 13
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [CNT_W:0]   entry_count_in,
  input  logic [31:0]      pos_base_in,
  input  logic [31:0]      nrm_base_in,
  input  logic [31:0]      mat_base_in,
  input  logic             abort_in,
  output logic             mem_req_valid_out,
  input  logic             mem_req_ready_in,
  output logic [31:0]      mem_req_addr_out,
  output logic [1:0]       mem_req_kind_out,
  input  logic             fifo_pop_valid_in,
  input  logic             fifo_pop_ready_in,
  output logic [CNT_W:0]   occupancy_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             underflow_out
);

  localparam int W = CNT_W + 1;
  localparam logic [CNT_W:0] FULL = W'(DEPTH);
  localparam logic [CNT_W:0] ONE  = W'(1);

  typedef enum logic [2:0] {
    IDLE,
    POS,
    NRM,
    MAT,
    DRAIN
  } state_t;

  state_t state;

  // The index is one bit wider than CNT_W so that any count the
  // count port can express is walkable without wrapping.
  logic [CNT_W:0] cnt;
  logic [CNT_W:0] idx;
  logic [CNT_W:0] idx_inc;
  logic [CNT_W:0] occ_next;
  logic [31:0]    pos_base;
  logic [31:0]    nrm_base;
  logic [31:0]    mat_base;

  logic hs;
  logic pop;
  logic take;
  logic last;
  logic room;
  logic issuing;

  always_comb begin
    hs      = mem_req_valid_out & mem_req_ready_in;
    pop     = fifo_pop_valid_in & fifo_pop_ready_in;
    take    = hs & (state == POS);
    issuing = (state == POS) | (state == NRM) | (state == MAT);
    idx_inc = idx + ONE;
    last    = (idx == cnt - ONE);

    occ_next = occupancy_out;
    if (take && !pop) begin
      occ_next = occupancy_out + ONE;
    end else if (pop && !take && occupancy_out != '0) begin
      occ_next = occupancy_out - ONE;
    end

    // POS valid is registered, so credit is judged on the occupancy
    // the FIFO will have once this cycle's pop/reserve has landed.
    room = (occ_next < FULL);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state             <= IDLE;
      cnt               <= '0;
      idx               <= '0;
      pos_base          <= '0;
      nrm_base          <= '0;
      mat_base          <= '0;
      mem_req_valid_out <= 1'b0;
      mem_req_addr_out  <= '0;
      mem_req_kind_out  <= 2'd0;
      occupancy_out     <= '0;
      busy_out          <= 1'b0;
      done_out          <= 1'b0;
      underflow_out     <= 1'b0;
    end else begin
      occupancy_out <= occ_next;
      done_out      <= 1'b0;
      if (pop && occupancy_out == '0) begin
        underflow_out <= 1'b1;
      end

      // A handshake in the abort cycle has already been counted
      // through occ_next above.
      if (abort_in && issuing) begin
        state             <= IDLE;
        mem_req_valid_out <= 1'b0;
        busy_out          <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_in) begin
              cnt      <= entry_count_in;
              idx      <= '0;
              pos_base <= pos_base_in;
              nrm_base <= nrm_base_in;
              mat_base <= mat_base_in;
              busy_out <= 1'b1;
              if (entry_count_in == '0) begin
                state <= DRAIN;
              end else begin
                state             <= POS;
                mem_req_valid_out <= room;
                mem_req_addr_out  <= pos_base_in;
                mem_req_kind_out  <= 2'd0;
              end
            end
          end
          POS: begin
            if (hs) begin
              state             <= NRM;
              mem_req_valid_out <= 1'b1;
              mem_req_addr_out  <= nrm_base + 32'(idx);
              mem_req_kind_out  <= 2'd1;
            end else begin
              mem_req_valid_out <= room;
            end
          end
          NRM: begin
            if (hs) begin
              state             <= MAT;
              mem_req_valid_out <= 1'b1;
              mem_req_addr_out  <= mat_base + 32'(idx);
              mem_req_kind_out  <= 2'd2;
            end
          end
          MAT: begin
            if (hs) begin
              if (last) begin
                state             <= DRAIN;
                mem_req_valid_out <= 1'b0;
              end else begin
                state             <= POS;
                idx               <= idx_inc;
                mem_req_valid_out <= room;
                mem_req_addr_out  <= pos_base + 32'(idx_inc);
                mem_req_kind_out  <= 2'd0;
              end
            end
          end
          DRAIN: begin
            if (occupancy_out == '0) begin
              state    <= IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end
          end
          default: begin
            state             <= IDLE;
            mem_req_valid_out <= 1'b0;
            busy_out          <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_triangle_fetch_scheduler.sv
// tb_triangle_fetch_scheduler: directed and randomized checks of the
// triangle fetch scheduler against a request/credit reference model.
module tb_triangle_fetch_scheduler;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             start_in;
  logic [CNT_W:0]   entry_count_in;
  logic [31:0]      pos_base_in;
  logic [31:0]      nrm_base_in;
  logic [31:0]      mat_base_in;
  logic             abort_in;
  logic             mem_req_valid_out;
  logic             mem_req_ready_in;
  logic [31:0]      mem_req_addr_out;
  logic [1:0]       mem_req_kind_out;
  logic             fifo_pop_valid_in;
  logic             fifo_pop_ready_in;
  logic [CNT_W:0]   occupancy_out;
  logic             busy_out;
  logic             done_out;
  logic             underflow_out;

  triangle_fetch_scheduler #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .start_in(start_in),
    .entry_count_in(entry_count_in),
    .pos_base_in(pos_base_in),
    .nrm_base_in(nrm_base_in),
    .mat_base_in(mat_base_in),
    .abort_in(abort_in),
    .mem_req_valid_out(mem_req_valid_out),
    .mem_req_ready_in(mem_req_ready_in),
    .mem_req_addr_out(mem_req_addr_out),
    .mem_req_kind_out(mem_req_kind_out),
    .fifo_pop_valid_in(fifo_pop_valid_in),
    .fifo_pop_ready_in(fifo_pop_ready_in),
    .occupancy_out(occupancy_out),
    .busy_out(busy_out),
    .done_out(done_out),
    .underflow_out(underflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the ordered list of requests still owed for the
  // current job, plus credit/status bookkeeping.
  logic [33:0] q[$];
  int  m_occ   = 0;
  bit  m_uf    = 0;
  bit  m_busy  = 0;
  bit  m_drain = 0;
  bit  e_done  = 0;
  int  n_hs    = 0;
  bit  p_valid = 0;
  bit  p_hs    = 0;
  bit  p_abort = 0;
  logic [31:0] p_addr = '0;
  logic [1:0]  p_kind = '0;

  always @(negedge clk_in) begin : mon
    logic [33:0] req;
    bit hs, popv, idle, issuing, inc;
    if (!rst_in) begin
      q.delete();
      m_occ   = 0;
      m_uf    = 0;
      m_busy  = 0;
      m_drain = 0;
      e_done  = 0;
      p_valid = 0;
      p_hs    = 0;
      p_abort = 0;
    end else begin
      check("occ", occupancy_out, m_occ);
      check("uflow", underflow_out, m_uf);
      check("busy", busy_out, m_busy);
      check("done", done_out, e_done);
      check("spur", mem_req_valid_out && q.size() == 0, 0);
      if (p_valid && !p_hs && !p_abort) begin
        check("hold_v", mem_req_valid_out, 1);
        check("hold_a", mem_req_addr_out, p_addr);
        check("hold_k", mem_req_kind_out, p_kind);
      end

      hs      = mem_req_valid_out && mem_req_ready_in;
      popv    = fifo_pop_valid_in && fifo_pop_ready_in;
      idle    = !m_busy;
      issuing = m_busy && !m_drain;
      inc     = 0;

      e_done = m_drain && m_occ == 0;
      if (e_done) begin
        m_drain = 0;
        m_busy  = 0;
      end

      if (hs && q.size() > 0) begin
        n_hs++;
        req = q.pop_front();
        check("kind", mem_req_kind_out, req[33:32]);
        check("addr", mem_req_addr_out, req[31:0]);
        if (req[33:32] == 2'd0) begin
          check("credit", m_occ < DEPTH, 1);
          inc = 1;
        end
        if (q.size() == 0) m_drain = 1;
      end

      if (abort_in && issuing) begin
        q.delete();
        m_busy  = 0;
        m_drain = 0;
      end

      if (start_in && idle) begin
        m_busy = 1;
        if (entry_count_in == '0) begin
          m_drain = 1;
        end else begin
          for (int i = 0; i < int'(entry_count_in); i++) begin
            q.push_back({2'd0, pos_base_in + 32'(i)});
            q.push_back({2'd1, nrm_base_in + 32'(i)});
            q.push_back({2'd2, mat_base_in + 32'(i)});
          end
        end
      end

      if (popv && m_occ == 0) m_uf = 1;
      if (inc && !popv) m_occ++;
      else if (popv && !inc && m_occ > 0) m_occ--;

      p_valid = mem_req_valid_out;
      p_hs    = hs;
      p_abort = abort_in;
      p_addr  = mem_req_addr_out;
      p_kind  = mem_req_kind_out;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pop(input bit v);
    fifo_pop_valid_in = v;
    fifo_pop_ready_in = v;
  endtask

  task automatic launch(input int cnt,
                        input logic [31:0] p,
                        input logic [31:0] n,
                        input logic [31:0] m);
    entry_count_in = (CNT_W + 1)'(cnt);
    pos_base_in    = p;
    nrm_base_in    = n;
    mat_base_in    = m;
    start_in       = 1'b1;
    tick();
    start_in       = 1'b0;
  endtask

  task automatic run_out(input int pop_pct, input bit chaos);
    for (int c = 0; c < 400 && m_busy; c++) begin
      mem_req_ready_in = ($urandom_range(0, 99) < 70);
      set_pop(m_occ > 0 && $urandom_range(0, 99) < pop_pct);
      abort_in = chaos && ($urandom_range(0, 99) < 3);
      start_in = chaos && ($urandom_range(0, 99) < 3);
      entry_count_in = (CNT_W + 1)'($urandom_range(0, 6));
      tick();
    end
    start_in         = 1'b0;
    abort_in         = 1'b0;
    mem_req_ready_in = 1'b0;
    set_pop(1'b0);
    check("timeout", m_busy, 0);
  endtask

  initial begin
    logic [31:0] b3 [3];
    logic [31:0] pb;
    int h0;

    rst_in           = 1'b0;
    start_in         = 1'b0;
    entry_count_in   = '0;
    pos_base_in      = '0;
    nrm_base_in      = '0;
    mat_base_in      = '0;
    abort_in         = 1'b0;
    mem_req_ready_in = 1'b0;
    set_pop(1'b0);

    #3;
    check("rst_valid", mem_req_valid_out, 0);
    check("rst_addr", mem_req_addr_out, 0);
    check("rst_kind", mem_req_kind_out, 0);
    check("rst_occ", occupancy_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_uflow", underflow_out, 0);
    tick();
    tick();
    rst_in = 1'b1;

    // pop with an empty FIFO
    tick();
    set_pop(1'b1);
    tick();
    set_pop(1'b0);
    @(negedge clk_in);
    check("uf_set", underflow_out, 1);
    check("uf_occ", occupancy_out, 0);

    // basic two-entry sequence
    tick();
    b3[0] = 32'h100;
    b3[1] = 32'h200;
    b3[2] = 32'h300;
    mem_req_ready_in = 1'b1;
    launch(2, b3[0], b3[1], b3[2]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      check("bs_v", mem_req_valid_out, 1);
      check("bs_k", mem_req_kind_out, 32'(i % 3));
      check("bs_a", mem_req_addr_out, b3[i % 3] + 32'(i / 3));
    end
    tick();
    mem_req_ready_in = 1'b0;
    set_pop(1'b1);
    tick();
    tick();
    set_pop(1'b0);
    @(negedge clk_in);
    check("bs_occ0", occupancy_out, 0);
    check("bs_nodone", done_out, 0);
    @(negedge clk_in);
    check("bs_done", done_out, 1);
    check("uf_stick", underflow_out, 1);

    // backpressure on the normal request
    tick();
    mem_req_ready_in = 1'b1;
    launch(1, 32'h1000, 32'h2000, 32'h3000);
    tick();
    mem_req_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("bp_v", mem_req_valid_out, 1);
      check("bp_k", mem_req_kind_out, 1);
      check("bp_a", mem_req_addr_out, 32'h2000);
      tick();
    end
    mem_req_ready_in = 1'b1;
    @(negedge clk_in);
    check("bp_k_last", mem_req_kind_out, 1);
    @(negedge clk_in);
    check("bp_k_mat", mem_req_kind_out, 2);
    check("bp_a_mat", mem_req_addr_out, 32'h3000);
    tick();
    run_out(60, 1'b0);

    // full FIFO then one pop to unblock
    tick();
    h0 = n_hs;
    mem_req_ready_in = 1'b1;
    pb = 32'h4000;
    launch(6, pb, 32'h5000, 32'h6000);
    repeat (30) tick();
    set_pop(1'b1);
    @(negedge clk_in);
    check("ff_hs", 32'(n_hs - h0), 12);
    check("ff_v", mem_req_valid_out, 0);
    check("ff_occ", occupancy_out, DEPTH);
    tick();
    @(negedge clk_in);
    check("ff_unblk_v", mem_req_valid_out, 1);
    check("ff_unblk_k", mem_req_kind_out, 0);
    check("ff_unblk_a", mem_req_addr_out, pb + 32'd4);
    check("ff_unblk_o", occupancy_out, DEPTH - 1);
    tick();
    set_pop(1'b0);
    @(negedge clk_in);
    check("sim_occ", occupancy_out, DEPTH - 1);
    check("sim_k", mem_req_kind_out, 1);
    tick();
    run_out(50, 1'b0);

    // abort while the material request is pending
    mem_req_ready_in = 1'b0;
    launch(3, 32'h7000, 32'h8000, 32'h9000);
    mem_req_ready_in = 1'b1;
    repeat (5) tick();
    mem_req_ready_in = 1'b0;
    @(negedge clk_in);
    check("ab_k", mem_req_kind_out, 2);
    check("ab_a", mem_req_addr_out, 32'h9001);
    check("ab_occ", occupancy_out, 2);
    tick();
    abort_in = 1'b1;
    tick();
    abort_in = 1'b0;
    @(negedge clk_in);
    check("ab_busy", busy_out, 0);
    check("ab_v", mem_req_valid_out, 0);
    check("ab_keep", occupancy_out, 2);
    tick();
    launch(1, 32'hA000, 32'hB000, 32'hC000);
    @(negedge clk_in);
    check("ab_restart", busy_out, 1);
    tick();
    run_out(50, 1'b0);

    // randomized jobs, including address wrap
    for (int j = 0; j < 25; j++) begin
      tick();
      if (j == 0) begin
        launch(5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      end else begin
        launch($urandom_range(0, 7), $urandom, $urandom, $urandom);
      end
      run_out($urandom_range(20, 70), 1'b1);
    end
    repeat (3) begin
      tick();
      if (m_occ > 0) run_out(80, 1'b0);
    end

    // reset in the middle of a job
    tick();
    mem_req_ready_in = 1'b1;
    launch(3, 32'hD000, 32'hE000, 32'hF000);
    tick();
    @(negedge clk_in);
    check("mr_k", mem_req_kind_out, 1);
    check("mr_occ1", occupancy_out, 1);
    #2;
    rst_in = 1'b0;
    #1;
    check("mr_v", mem_req_valid_out, 0);
    check("mr_occ", occupancy_out, 0);
    check("mr_busy", busy_out, 0);
    check("mr_uf", underflow_out, 0);
    mem_req_ready_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;

    // zero-count job
    tick();
    launch(0, 32'h0, 32'h0, 32'h0);
    @(negedge clk_in);
    check("zc_early", done_out, 0);
    @(negedge clk_in);
    check("zc_done", done_out, 1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
